// File: rtl/seg_frame_ctrl.sv
// Segment frame controller: encodes 8 hex digits into a 64-bit frame and runs the serializer handshake.
// Optional build macro SEG_BLANK_LEADING_ZERO_EN enables leading-zero suppression.
module seg_frame_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hex_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  input  logic        update,
  input  logic        finish,
  output logic [63:0] seg,
  output logic        start,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned RW = $clog2(REFRESH_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT_ACK, S_WAIT_DONE} state_e;

  state_e        state_q, state_d;
  logic [63:0]   seg_q, seg_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [31:0]   hex_q, hex_d;
  logic [7:0]    dp_q, dp_d;
  logic [7:0]    blank_q, blank_d;
  logic          pending_q, pending_d;
  logic          refresh_req_q, refresh_req_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ref_wrap_c;
  logic          timeout_c;
  logic [63:0]   frame_c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  // Builds the frame from the shadow registers; blanked digits drop dp as well.
  function automatic logic [63:0] encode_frame(input logic [31:0] hex, input logic [7:0] dp,
                                               input logic [7:0] blank);
    logic [7:0]  kill;
    logic [7:0]  byte_v;
    logic [63:0] frame;
    kill = blank;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    begin : lz_blk
      logic lz;
      lz = 1'b1;
      for (int i = 7; i >= 1; i--) begin
        if (lz && (hex[4*i +: 4] == 4'h0) && !dp[i]) kill[i] = 1'b1;
        else lz = 1'b0;
      end
    end
`endif
    frame = '0;
    for (int i = 0; i < 8; i++) begin
      byte_v = kill[i] ? 8'h00 : {dp[i], seg7(hex[4*i +: 4])};
      frame[8*i +: 8] = ACTIVE_LOW ? ~byte_v : byte_v;
    end
    return frame;
  endfunction

  assign frame_c    = encode_frame(hex_q, dp_q, blank_q);
  assign ref_wrap_c = (ref_cnt_q == RW'(REFRESH_CYCLES - 1));
  assign timeout_c  = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      seg_q         <= ACTIVE_LOW ? '1 : '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      hex_q         <= '0;
      dp_q          <= '0;
      blank_q       <= 8'hFF;
      pending_q     <= 1'b1;
      refresh_req_q <= 1'b0;
      ref_cnt_q     <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      seg_q         <= seg_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      hex_q         <= hex_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      pending_q     <= pending_d;
      refresh_req_q <= refresh_req_d;
      ref_cnt_q     <= ref_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    seg_d         = seg_q;
    start_d       = 1'b0;
    err_d         = err_q;
    hex_d         = hex_q;
    dp_d          = dp_q;
    blank_d       = blank_q;
    pending_d     = pending_q;
    refresh_req_d = refresh_req_q;
    ref_cnt_d     = ref_wrap_c ? '0 : ref_cnt_q + RW'(1);
    to_cnt_d      = to_cnt_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (pending_q || refresh_req_q) begin
          pending_d     = 1'b0;
          refresh_req_d = 1'b0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        seg_d    = frame_c;
        to_cnt_d = '0;
        state_d  = S_ARM;
      end
      S_ARM: begin
        if (finish) begin
          start_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = S_WAIT_ACK;
        end else if (timeout_c) begin
          err_d     = 1'b1;
          pending_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        if (!finish) begin
          to_cnt_d = '0;
          state_d  = S_WAIT_DONE;
        end else if (timeout_c) begin
          err_d     = 1'b1;
          pending_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (finish) begin
          state_d = S_IDLE;
        end else if (timeout_c) begin
          err_d     = 1'b1;
          pending_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Requests arriving this edge take priority over the IDLE consume.
    if (ref_wrap_c) refresh_req_d = 1'b1;
    if (update) begin
      hex_d     = hex_in;
      dp_d      = dp_in;
      blank_d   = blank_in;
      pending_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign seg         = seg_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_seg_frame_ctrl.sv
// Directed self-checking bench for seg_frame_ctrl: one handshake-driven instance, one refresh instance.
module tb_seg_frame_ctrl;

  localparam int unsigned TO_A = 32;
  localparam logic [63:0] ALL_OFF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_X1  = 64'h8090868E9282F880;
  localparam logic [63:0] EXP_T3  = 64'hFFF9A4B08883C621;
`ifdef SEG_BLANK_LEADING_ZERO_EN
  localparam logic [63:0] EXP_T2  = 64'hFFF9A4B08883C6A1;
  localparam logic [63:0] EXP_450 = 64'hFFFFFFFFFF9992C0;
`else
  localparam logic [63:0] EXP_T2  = 64'hC0F9A4B08883C6A1;
  localparam logic [63:0] EXP_450 = 64'hC0C0C0C0C09992C0;
`endif

  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic [31:0] hex_a;
  logic [7:0]  dp_a, blank_a;
  logic        update_a, finish_a;
  logic [63:0] seg_a;
  logic        start_a, busy_a, err_a;
  logic [31:0] hex_b = '0;
  logic [7:0]  dp_b = '0, blank_b = '0;
  logic        update_b = 1'b0;
  logic        finish_b;
  logic [63:0] seg_b;
  logic        start_b, busy_b, err_b;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int starts_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_frame_ctrl #(.REFRESH_CYCLES(100000), .TIMEOUT_CYCLES(TO_A), .ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rst(rst), .hex_in(hex_a), .dp_in(dp_a), .blank_in(blank_a), .update(update_a),
    .finish(finish_a), .seg(seg_a), .start(start_a), .busy(busy_a), .err_timeout(err_a)
  );

  seg_frame_ctrl #(.REFRESH_CYCLES(100), .TIMEOUT_CYCLES(256), .ACTIVE_LOW(1'b1)) u_ref (
    .clk(clk), .rst(rst_b), .hex_in(hex_b), .dp_in(dp_b), .blank_in(blank_b), .update(update_b),
    .finish(finish_b), .seg(seg_b), .start(start_b), .busy(busy_b), .err_timeout(err_b)
  );

  // Serializer model for the refresh instance: ~66 cycles per frame.
  initial begin
    finish_b = 1'b1;
    forever begin
      @(negedge clk);
      if (start_b) begin
        finish_b = 1'b0;
        repeat (64) @(negedge clk);
        finish_b = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (start_b) starts_b.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_update(input logic [31:0] h, input logic [7:0] d, input logic [7:0] b);
    hex_a    = h;
    dp_a     = d;
    blank_a  = b;
    update_a = 1'b1;
  endtask

  // Returns the negedge index (1-based) where start is first seen, -1 if never.
  task automatic wait_start(input int bound, output int lat);
    int i;
    lat = -1;
    i   = 0;
    while (lat < 0 && i < bound) begin
      @(negedge clk);
      update_a = 1'b0;
      i++;
      if (start_a) lat = i;
    end
  endtask

  task automatic wait_idle(input int bound, output int ok);
    int i;
    ok = 0;
    i  = 0;
    while (ok == 0 && i < bound) begin
      @(negedge clk);
      i++;
      if (!busy_a) ok = 1;
    end
  endtask

  task automatic serve(input int low, output int ok);
    finish_a = 1'b0;
    repeat (low) @(negedge clk);
    finish_a = 1'b1;
    wait_idle(10, ok);
  endtask

  initial begin
    int lat, ok, n, extra;
    rst = 1'b1; rst_b = 1'b1; finish_a = 1'b1; update_a = 1'b0;
    hex_a = '0; dp_a = '0; blank_a = '0;
    repeat (3) @(negedge clk);
    check("rst_seg", seg_a, ALL_OFF);
    check("rst_start", 64'(start_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    rst = 1'b0; rst_b = 1'b0;

    // Blank frame pending out of reset.
    wait_start(10, lat);
    check("blank_lat", 64'(lat), 64'd3);
    check("blank_seg", seg_a, ALL_OFF);
    @(negedge clk);
    check("start_one_cycle", 64'(start_a), 64'd0);
    check("blank_busy", 64'(busy_a), 64'd1);
    serve(5, ok);
    check("blank_done", 64'(ok), 64'd1);

    send_update(32'h0123ABCD, 8'h00, 8'h00);
    wait_start(10, lat);
    check("upd_lat", 64'(lat), 64'd4);
    check("upd_seg", seg_a, EXP_T2);
    serve(5, ok);
    check("upd_done", 64'(ok), 64'd1);

    send_update(32'h0123ABCD, 8'h01, 8'h80);
    wait_start(10, lat);
    check("dp_blank_lat", 64'(lat), 64'd4);
    check("dp_blank_seg", seg_a, EXP_T3);
    serve(5, ok);
    check("dp_blank_done", 64'(ok), 64'd1);

    // Serializer never returns finish: timeout, then retry.
    send_update(32'h0123ABCD, 8'h00, 8'h00);
    wait_start(10, lat);
    finish_a = 1'b0;
    n = 0;
    while (!err_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_window", 64'((n >= int'(TO_A)) && (n <= int'(TO_A) + 4)), 64'd1);
    check("to_err", 64'(err_a), 64'd1);
    repeat (3) @(negedge clk);
    check("to_retry_busy", 64'(busy_a), 64'd1);
    check("to_retry_nostart", 64'(start_a), 64'd0);
    finish_a = 1'b1;
    wait_start(5, lat);
    check("to_retry_start", 64'(lat), 64'd1);
    check("to_retry_seg", seg_a, EXP_T2);
    serve(5, ok);
    check("to_retry_done", 64'(ok), 64'd1);
    check("err_sticky", 64'(err_a), 64'd1);

    // Updates while a frame is in flight: last one wins, one further frame.
    send_update(32'h89EF5678, 8'h00, 8'h00);
    wait_start(10, lat);
    check("inflight_seg", seg_a, EXP_X1);
    finish_a = 1'b0;
    repeat (3) @(negedge clk);
    send_update(32'hFFFFFFFF, 8'hFF, 8'h00);
    @(negedge clk);
    send_update(32'h00000450, 8'h00, 8'h00);
    @(negedge clk);
    update_a = 1'b0;
    repeat (3) @(negedge clk);
    check("inflight_hold", seg_a, EXP_X1);
    check("inflight_busy", 64'(busy_a), 64'd1);
    finish_a = 1'b1;
    wait_start(20, lat);
    check("second_lat", 64'(lat), 64'd4);
    check("second_seg", seg_a, EXP_450);
    serve(5, ok);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (start_a) extra++;
    end
    check("no_extra_frame", 64'(extra), 64'd0);

    // Reset just before start would fire.
    send_update(32'h0123ABCD, 8'h00, 8'h00);
    @(negedge clk);
    update_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_start", 64'(start_a), 64'd0);
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_seg", seg_a, ALL_OFF);
    check("midrst_err", 64'(err_a), 64'd0);
    rst = 1'b0;
    wait_start(10, lat);
    check("midrst_blank_lat", 64'(lat), 64'd3);
    serve(5, ok);
    check("midrst_done", 64'(ok), 64'd1);

    // Refresh instance: frames every 100 cycles with no updates.
    while (cyc < 700) @(negedge clk);
    check("ref_count", 64'(starts_b.size() >= 5), 64'd1);
    if (starts_b.size() >= 5) begin
      for (int k = 1; k <= 3; k++)
        check($sformatf("ref_period%0d", k), 64'(starts_b[k+1] - starts_b[k]), 64'd100);
    end
    check("ref_seg", seg_b, ALL_OFF);
    check("ref_err", 64'(err_b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
